// File: rtl/spi_master_v3_if.sv
// spi_master_v3_if - local-side handshake and SPI bus bundle for spi_master_v3.
//   master modport : the SPI master block (drives tx_ready/rx/status and SPI pins)
//   slave modport  : the producer/consumer side plus the external MISO driver
// Widths follow the block parameters; instantiate with the same DATA_W/NUM_CS
// as the connected spi_master_v3.
interface spi_master_v3_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CS = 1,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [CS_W-1:0]   cs_sel_i;
  logic              cpol_i;
  logic              cpha_i;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              busy_o;
  logic [CNT_W-1:0]  bit_cnt_o;
  logic [NUM_CS-1:0] spi_cs_n_o;
  logic              spi_sclk_o;
  logic              spi_mosi_o;
  logic              spi_miso_i;

  modport master (
    input  tx_data_i, tx_valid_i, cs_sel_i, cpol_i, cpha_i, spi_miso_i,
    output tx_ready_o, rx_data_o, rx_valid_o, busy_o, bit_cnt_o,
           spi_cs_n_o, spi_sclk_o, spi_mosi_o
  );

  modport slave (
    output tx_data_i, tx_valid_i, cs_sel_i, cpol_i, cpha_i, spi_miso_i,
    input  tx_ready_o, rx_data_o, rx_valid_o, busy_o, bit_cnt_o,
           spi_cs_n_o, spi_sclk_o, spi_mosi_o
  );
endinterface

// File: rtl/spi_master_v3.sv
// spi_master_v3 - parametrised SPI master (all CPOL/CPHA modes, MSB/LSB first,
// NUM_CS chip selects, MISO capture, valid/ready transmit handshake).
// Ports:
//   clk_i   : system clock
//   arst_ni : asynchronous active-low reset
//   bus     : spi_master_v3_if.master (tx handshake, rx result, status, SPI pins)
//
// state | meaning
// IDLE  | ready for a word, SCLK follows cpol_i
// SETUP | CS asserted, first bit on MOSI, SCLK at CPOL for one half-period
// XFER  | SCLK toggling; sample/drive per CPHA; last tick closes final half-period
// HOLD  | CS still low, lines stable
// GAP   | CS high, MOSI low, rx_data updated; minimum CS-high time
module spi_master_v3 #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 2,
  parameter int NUM_CS    = 1,
  parameter bit LSB_FIRST = 1'b0,
  parameter int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  parameter int CNT_W     = $clog2(DATA_W + 1)
) (
  input logic             clk_i,
  input logic             arst_ni,
  spi_master_v3_if.master bus
);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic [EDGE_W-1:0] edge_q, edge_n;
  logic              tick, accept, sclk_edge, do_sample, do_drive;
  logic              cpol_q, cpha_q;
  logic [DATA_W-1:0] tx_sh_q, rx_sh_q, rx_data_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [NUM_CS-1:0] cs_n_q;
  logic              sclk_q, mosi_q, rx_valid_q;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    sclk_edge = 1'b0;
    do_sample = 1'b0;
    do_drive  = 1'b0;
    edge_n    = edge_q + EDGE_W'(1);
    unique case (state_q)
      IDLE: begin
        if (bus.tx_valid_i) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_edge = 1'b1;
          state_d   = XFER;
        end
      end
      XFER: begin
        // Edges 2..2*DATA_W toggle SCLK; the tick after the last edge only
        // closes the final half-period before HOLD.
        if (tick) begin
          if (edge_q == EDGE_LAST) state_d = HOLD;
          else                     sclk_edge = 1'b1;
        end
      end
      HOLD:    if (tick) state_d = GAP;
      GAP:     if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Odd edge numbers are leading edges. CPHA=0 samples on leading, CPHA=1
    // on trailing; the other edge drives, except bit 0 (driven at accept) and
    // the final trailing edge (no bit left).
    if (sclk_edge) begin
      do_sample = edge_n[0] ^ cpha_q;
      do_drive  = !(edge_n[0] ^ cpha_q) && (edge_n != EDGE_W'(1)) && (edge_n != EDGE_LAST);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || tick || state_q == IDLE) div_q <= '0;
      else                                                div_q <= div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      edge_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      cs_n_q     <= '1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (state_q == IDLE) sclk_q <= bus.cpol_i;
      if (accept) begin
        tx_sh_q   <= bus.tx_data_i;
        rx_sh_q   <= '0;
        edge_q    <= '0;
        bit_cnt_q <= '0;
        cpol_q    <= bus.cpol_i;
        cpha_q    <= bus.cpha_i;
        mosi_q    <= LSB_FIRST ? bus.tx_data_i[0] : bus.tx_data_i[DATA_W-1];
        // An index beyond NUM_CS matches no line: the transfer runs with no CS.
        for (int i = 0; i < NUM_CS; i++) cs_n_q[i] <= (bus.cs_sel_i != CS_W'(i));
      end
      if (sclk_edge) begin
        sclk_q <= ~sclk_q;
        edge_q <= edge_n;
      end
      if (do_sample) begin
        if (LSB_FIRST) rx_sh_q <= {bus.spi_miso_i, rx_sh_q[DATA_W-1:1]};
        else           rx_sh_q <= {rx_sh_q[DATA_W-2:0], bus.spi_miso_i};
        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      if (do_drive) begin
        if (LSB_FIRST) begin
          tx_sh_q <= tx_sh_q >> 1;
          mosi_q  <= tx_sh_q[1];
        end else begin
          tx_sh_q <= tx_sh_q << 1;
          mosi_q  <= tx_sh_q[DATA_W-2];
        end
      end
      if (state_q == HOLD && tick) begin
        cs_n_q     <= '1;
        mosi_q     <= 1'b0;
        rx_data_q  <= rx_sh_q;
        rx_valid_q <= 1'b1;
      end
    end
  end

  assign bus.tx_ready_o = (state_q == IDLE);
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.rx_data_o  = rx_data_q;
  assign bus.rx_valid_o = rx_valid_q;
  assign bus.bit_cnt_o  = bit_cnt_q;
  assign bus.spi_cs_n_o = cs_n_q;
  assign bus.spi_sclk_o = sclk_q;
  assign bus.spi_mosi_o = mosi_q;
endmodule

// File: doc/spi_master_v3.md
Name: spi_master_v3

Overview:
Parametrised SPI master, the successor to the fixed 16-bit, mode-0-only, transmit-only SPI master. Adds configurable word width, SCLK divider, all four CPOL/CPHA modes, MSB/LSB-first order, multiple chip selects, MISO capture, and a valid/ready transmit handshake. It sits between a local register/FIFO producer and external SPI slaves.

Parameters:
DATA_W, 16, bits per transfer (>=2)
CLK_DIV, 2, clk_i cycles per SCLK half-period (>=1)
NUM_CS, 1, number of chip-select lines (>=1)
LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB shifted first
CS_W, (NUM_CS>1 ? $clog2(NUM_CS) : 1), derived width of cs_sel_i
CNT_W, $clog2(DATA_W+1), derived width of bit_cnt_o

Ports:
clk_i  in  1  system clock
arst_ni  in  1  asynchronous active-low reset
tx_data_i  in  DATA_W  word to transmit
tx_valid_i  in  1  tx_data_i/cs_sel_i/cpol_i/cpha_i valid
tx_ready_o  out  1  block can accept a word
cs_sel_i  in  CS_W  chip select index for the transfer
cpol_i  in  1  SCLK idle level
cpha_i  in  1  0: sample on leading edge, 1: sample on trailing edge
rx_data_o  out  DATA_W  last received word
rx_valid_o  out  1  one-cycle pulse, rx_data_o updated
busy_o  out  1  transfer in progress
bit_cnt_o  out  CNT_W  bits sampled in current transfer
spi_cs_n_o  out  NUM_CS  active-low chip selects
spi_sclk_o  out  1  SPI clock
spi_mosi_o  out  1  master out
spi_miso_i  in  1  master in

Behaviour:
- One clock domain, clk_i. Reset is asynchronous and active-low on arst_ni. All SPI outputs are registered.
- Reset values: spi_cs_n_o all 1, spi_sclk_o 0, spi_mosi_o 0, rx_data_o 0, rx_valid_o 0, busy_o 0, bit_cnt_o 0, tx_ready_o 1. The FSM resets to IDLE.
- Reset asserted mid-transfer aborts the transfer immediately. No rx_valid_o pulse is produced.
- Half-period tick: the divider counts 0..CLK_DIV-1 and ticks at CLK_DIV-1. It clears on every state entry.
- FSM states: IDLE, SETUP, XFER, HOLD, GAP.
- IDLE:
  - tx_ready_o=1, busy_o=0.
  - spi_sclk_o <= cpol_i every cycle.
  - Accept when tx_valid_i && tx_ready_o. On accept, latch tx_data_i, cs_sel_i, cpol_i, cpha_i, clear bit_cnt_o, and go to SETUP.
  - tx_ready_o is 0 from the next cycle.
- SETUP (CLK_DIV cycles):
  - spi_cs_n_o[cs_sel] <= 0; all others stay 1.
  - If cs_sel >= NUM_CS, no CS is asserted, but the transfer still runs.
  - spi_mosi_o = first bit (MSB, or LSB when LSB_FIRST).
  - SCLK holds at CPOL. On the tick, toggle SCLK (leading edge of bit 0) and go to XFER.
- XFER (2*DATA_W-1 further ticks):
  - Each tick toggles SCLK.
  - Leading edges: CPHA=0 samples MISO; CPHA=1 drives the next bit (bit 0 is already driven).
  - Trailing edges: CPHA=0 drives the next bit; CPHA=1 samples MISO.
  - Sampling and driving happen on the clk_i edge that produces the SCLK edge.
  - The first sampled bit lands in rx shift position DATA_W-1 (MSB-first) or 0 (LSB-first).
  - bit_cnt_o increments at each sample.
  - After the final trailing edge (SCLK back at CPOL), go to HOLD.
- HOLD (CLK_DIV cycles): CS stays low and the lines are stable. At the end, go to GAP.
- Entering GAP:
  - All CS go to 1 and spi_mosi_o goes to 0.
  - rx_data_o <= shift register and rx_valid_o = 1 for exactly one cycle.
  - GAP lasts CLK_DIV cycles, then the FSM returns to IDLE.
- busy_o is 1 in SETUP, XFER, HOLD and GAP.
- Duration: (2*DATA_W+3)*CLK_DIV cycles from the accept edge to tx_ready_o returning to 1.
- Minimum CS-high time between back-to-back transfers is CLK_DIV+1 cycles.
- tx_* inputs are ignored while busy. rx_data_o holds until the next completion.
- A cpol_i change while busy takes effect only after return to IDLE.

Test Plan:
1. DATA_W=16, CLK_DIV=2, mode 0, MOSI looped to MISO, tx 0xA5C3 -> 16 rising SCLK edges while CS0 low, rx_data_o=0xA5C3 with a single rx_valid_o pulse, tx_ready_o low for 70 cycles.
2. Mode 3, slave model returns 0x1234 sampled on rising SCLK -> SCLK idles 1 before and after, rx_data_o=0x1234, MOSI changes only on falling SCLK edges.
3. tx_valid_i held high with words 0x0F0F then 0xF0F0 -> second word accepted on the first IDLE cycle, CS high for exactly 3 cycles between transfers, both words seen on MOSI.
4. NUM_CS=4, cs_sel_i=2 -> only spi_cs_n_o[2] low. Then cs_sel_i=5 (CS_W=2 wraps to 1) -> spi_cs_n_o[1] low. Also cover NUM_CS=3 with cs_sel_i=3 -> no CS low and rx_valid_o still pulses.
5. arst_ni pulled low after 5 bits -> all outputs go to reset values without a clock edge and no rx_valid_o pulse. A following 0x00FF transfer completes correctly.
6. LSB_FIRST=1, DATA_W=8, CLK_DIV=1, tx 0x01 -> MOSI high only during the first bit, rx loopback gives 0x01, total busy time 19 cycles.
